// File: rtl/mem_store_rmw_pkg.sv
// Purpose : shared store/load-side definitions: FSM states and size encodings.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
// Contents: state_t (IDLE/READ/WRITE), SZ_WORD/SZ_BYTE size codes, BYTE_W.
package mem_store_rmw_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_t;

  // Store/load size encoding as carried on StSrc.
  localparam logic SZ_WORD = 1'b0;
  localparam logic SZ_BYTE = 1'b1;

  localparam int BYTE_W = 8;

endpackage

// File: rtl/mem_store_rmw_byte_merge.sv
// Purpose : insert one byte into a word at a little-endian lane index.
// Latency : combinational, zero cycles.
// Backpressure: none (pure function of inputs).
// Ports   : i_word (original word), i_lane (byte lane, 0 = bits 7:0),
//           i_byte (replacement byte), o_word (merged word).
module byte_merge
  import mem_store_rmw_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] i_word,
  input  logic [1:0]            i_lane,
  input  logic [BYTE_W-1:0]     i_byte,
  output logic [DATA_WIDTH-1:0] o_word
);

  always_comb begin
    o_word = i_word;
    o_word[{i_lane, 3'b000} +: BYTE_W] = i_byte;
  end

endmodule

// File: rtl/mem_store_rmw.sv
// Purpose : store unit; SW writes directly, SB does read-modify-write of the word.
// Latency : SW aligned zero added cycles; SB occupies 3 cycles (accept, READ, WRITE).
// Backpressure: Stall high for the accept and READ cycles of an SB; inputs held by pipeline.
// Ports   : clk/rst (sync active-high); WE/StSrc/A/WD store request; Stall to pipeline;
//           mem_addr/mem_re/mem_rd/mem_we/mem_wd word memory port; misalign sticky SW error.
module mem_store_rmw
  import mem_store_rmw_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  WE,
  input  logic                  StSrc,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] WD,
  output logic                  Stall,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic                  mem_re,
  input  logic [DATA_WIDTH-1:0] mem_rd,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wd,
  output logic                  misalign
);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [DATA_WIDTH-1:0]   r_addr;      // full byte address of the SB in flight
  logic [BYTE_W-1:0]       r_byte;
  logic                    r_done;      // an SB just completed its WRITE
  logic                    r_misalign;
  logic                    w_accept_sb;
  logic                    w_set_mis;
  logic                    w_same_req;
  logic [DATA_WIDTH-1:0]   w_merged;

  byte_merge #(.DATA_WIDTH(DATA_WIDTH)) u_byte_merge (
    .i_word (mem_rd),
    .i_lane (r_addr[1:0]),
    .i_byte (r_byte),
    .o_word (w_merged)
  );

  // The pipeline may still present the completed SB in the cycle after WRITE;
  // that is the same store and must not be replayed.
  assign w_same_req = r_done && (StSrc == SZ_BYTE) && (A == r_addr);

  assign misalign = r_misalign;

  always_comb begin
    w_state_nxt = r_state;
    Stall       = 1'b0;
    mem_re      = 1'b0;
    mem_we      = 1'b0;
    mem_wd      = '0;
    mem_addr    = {A[DATA_WIDTH-1:2], 2'b00};
    w_accept_sb = 1'b0;
    w_set_mis   = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (WE && !w_same_req) begin
          if (StSrc == SZ_WORD) begin
            if (A[1:0] == 2'b00) begin
              mem_we = 1'b1;
              mem_wd = WD;
            end else begin
              w_set_mis = 1'b1;
            end
          end else begin
            w_accept_sb = 1'b1;
            mem_re      = 1'b1;
            Stall       = 1'b1;
            w_state_nxt = READ;
          end
        end
      end
      READ: begin
        Stall       = 1'b1;
        mem_addr    = {r_addr[DATA_WIDTH-1:2], 2'b00};
        w_state_nxt = WRITE;
      end
      WRITE: begin
        mem_addr    = {r_addr[DATA_WIDTH-1:2], 2'b00};
        mem_we      = 1'b1;
        mem_wd      = w_merged;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    // Reset is sampled this edge: abort whatever is in flight and keep the
    // memory port quiet so a half-done SB can never write.
    if (rst) begin
      w_state_nxt = IDLE;
      Stall       = 1'b0;
      mem_re      = 1'b0;
      mem_we      = 1'b0;
      mem_wd      = '0;
      w_accept_sb = 1'b0;
      w_set_mis   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_byte     <= '0;
      r_done     <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept_sb) begin
        r_addr <= A;
        r_byte <= WD[BYTE_W-1:0];
      end
      if (w_set_mis) begin
        r_misalign <= 1'b1;
      end
      // Suppression lasts exactly one IDLE cycle after WRITE.
      if (r_state == WRITE) begin
        r_done <= 1'b1;
      end else if (r_state == IDLE) begin
        r_done <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_store_rmw.sv
module tb_mem_store_rmw;

  logic        clk;
  logic        rst;
  logic        WE;
  logic        StSrc;
  logic [31:0] A;
  logic [31:0] WD;
  logic        Stall;
  logic [31:0] mem_addr;
  logic        mem_re;
  logic [31:0] mem_rd;
  logic        mem_we;
  logic [31:0] mem_wd;
  logic        misalign;

  logic [31:0] mem_word;
  int          we_cnt;
  int          overlap_cnt;
  int          n_pass;
  int          n_total;

  mem_store_rmw #(.DATA_WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .WE       (WE),
    .StSrc    (StSrc),
    .A        (A),
    .WD       (WD),
    .Stall    (Stall),
    .mem_addr (mem_addr),
    .mem_re   (mem_re),
    .mem_rd   (mem_rd),
    .mem_we   (mem_we),
    .mem_wd   (mem_wd),
    .misalign (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: one-cycle synchronous read of the word the bench has staged.
  always @(posedge clk) begin
    if (mem_re) mem_rd <= mem_word;
  end

  // Observe the settled memory strobes mid-cycle.
  always @(negedge clk) begin
    if (mem_we) we_cnt++;
    if (mem_we && mem_re) overlap_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full SB sequence; returns in the WRITE cycle with the request still held.
  task automatic sb_store(input string tag, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] word, input logic [31:0] exp_wd);
    mem_word = word;
    WE = 1'b1; StSrc = 1'b1; A = a; WD = wd;
    #1;
    chk1({tag, "_acc_stall"}, Stall, 1'b1);
    chk1({tag, "_acc_re"}, mem_re, 1'b1);
    chk1({tag, "_acc_we"}, mem_we, 1'b0);
    tick();
    #1;
    chk1({tag, "_rd_stall"}, Stall, 1'b1);
    chk1({tag, "_rd_re"}, mem_re, 1'b0);
    chk1({tag, "_rd_we"}, mem_we, 1'b0);
    tick();
    #1;
    chk1({tag, "_wr_stall"}, Stall, 1'b0);
    chk1({tag, "_wr_we"}, mem_we, 1'b1);
    chk ({tag, "_wr_addr"}, mem_addr, {a[31:2], 2'b00});
    chk ({tag, "_wr_wd"}, mem_wd, exp_wd);
  endtask

  initial begin
    n_pass = 0; n_total = 0; we_cnt = 0; overlap_cnt = 0;
    mem_word = 32'h0; mem_rd = 32'h0;
    rst = 1'b1; WE = 1'b0; StSrc = 1'b0; A = 32'h0; WD = 32'h0;
    tick();
    // Aligned SW presented during reset must not reach memory.
    WE = 1'b1; StSrc = 1'b0; A = 32'h100; WD = 32'h12345678;
    #1;
    chk1("rst_we", mem_we, 1'b0);
    chk1("rst_re", mem_re, 1'b0);
    chk1("rst_stall", Stall, 1'b0);
    chk ("rst_wd", mem_wd, 32'h0);
    chk1("rst_misalign", misalign, 1'b0);
    WE = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    chk1("idle_we", mem_we, 1'b0);
    chk1("idle_re", mem_re, 1'b0);
    chk1("idle_stall", Stall, 1'b0);

    // Aligned SW: same-cycle write.
    tick();
    we_cnt = 0;
    WE = 1'b1; StSrc = 1'b0; A = 32'h100; WD = 32'hDEADBEEF;
    #1;
    chk1("sw_we", mem_we, 1'b1);
    chk ("sw_addr", mem_addr, 32'h100);
    chk ("sw_wd", mem_wd, 32'hDEADBEEF);
    chk1("sw_stall", Stall, 1'b0);
    chk1("sw_re", mem_re, 1'b0);
    tick();
    WE = 1'b0;
    tick();
    chk ("sw_we_cnt", we_cnt, 1);

    // SB lane 2 read-modify-write; request then held one extra cycle.
    we_cnt = 0;
    sb_store("sb102", 32'h102, 32'h000000AB, 32'h11223344, 32'h11AB3344);
    tick();
    #1;
    chk1("sb_hold_we", mem_we, 1'b0);
    chk1("sb_hold_re", mem_re, 1'b0);
    chk1("sb_hold_stall", Stall, 1'b0);
    WE = 1'b0;
    tick();
    chk ("sb_we_cnt", we_cnt, 1);

    // Lane boundaries.
    sb_store("sb_l0", 32'h200, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFF00);
    tick();
    WE = 1'b0;
    tick();
    sb_store("sb_l3", 32'h203, 32'hCAFE0000, 32'hFFFFFFFF, 32'h00FFFFFF);
    tick();
    WE = 1'b0;
    tick();

    // Back-to-back SB then SW.
    we_cnt = 0;
    sb_store("b2b_sb", 32'h301, 32'h0000005A, 32'hAABBCCDD, 32'hAABB5ADD);
    tick();
    WE = 1'b1; StSrc = 1'b0; A = 32'h304; WD = 32'h87654321;
    #1;
    chk1("b2b_sw_we", mem_we, 1'b1);
    chk ("b2b_sw_addr", mem_addr, 32'h304);
    chk ("b2b_sw_wd", mem_wd, 32'h87654321);
    tick();
    WE = 1'b0;
    tick();
    chk ("b2b_we_cnt", we_cnt, 2);

    // Misaligned SW: no write, sticky flag.
    we_cnt = 0;
    WE = 1'b1; StSrc = 1'b0; A = 32'h101; WD = 32'h55555555;
    #1;
    chk1("mis_we", mem_we, 1'b0);
    chk1("mis_before", misalign, 1'b0);
    tick();
    A = 32'h104;
    #1;
    chk1("mis_set", misalign, 1'b1);
    chk1("mis_aligned_we", mem_we, 1'b1);
    tick();
    WE = 1'b0;
    tick();
    chk1("mis_sticky", misalign, 1'b1);
    chk ("mis_we_cnt", we_cnt, 1);

    // Reset during READ aborts the SB.
    we_cnt = 0;
    mem_word = 32'h0;
    WE = 1'b1; StSrc = 1'b1; A = 32'h400; WD = 32'h00000077;
    tick();
    #1;
    chk1("abort_read_stall", Stall, 1'b1);
    rst = 1'b1; WE = 1'b0;
    #1;
    chk1("abort_rst_we", mem_we, 1'b0);
    chk1("abort_rst_stall", Stall, 1'b0);
    tick();
    rst = 1'b0;
    #1;
    chk1("abort_idle_stall", Stall, 1'b0);
    chk1("abort_idle_we", mem_we, 1'b0);
    chk1("abort_mis_clr", misalign, 1'b0);
    tick();
    tick();
    chk ("abort_we_cnt", we_cnt, 0);
    WE = 1'b1; StSrc = 1'b0; A = 32'h500; WD = 32'h0BADF00D;
    #1;
    chk1("post_abort_sw_we", mem_we, 1'b1);
    chk ("post_abort_sw_addr", mem_addr, 32'h500);
    tick();
    WE = 1'b0;
    tick();

    chk ("we_re_overlap", overlap_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_store_rmw.md
MEM_STORE_RMW -- requirements
Module: mem_store_rmw

Interface
REQ-001 Parameter DATA_WIDTH, default 32: data and address width.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 WE  input  1  store request from the pipeline, sampled each cycle.
REQ-005 StSrc  input  1  store size: 0 = word (SW), 1 = byte (SB).
REQ-006 A  input  DATA_WIDTH  store byte address.
REQ-007 WD  input  DATA_WIDTH  store data; SB uses WD[7:0].
REQ-008 Stall  output  1  high while a request is in progress; the pipeline holds WE/StSrc/A/WD stable while high.
REQ-009 mem_addr  output  DATA_WIDTH  word-aligned memory address, {A[31:2],2'b00}.
REQ-010 mem_re  output  1  memory read strobe; read data is valid on mem_rd the cycle after.
REQ-011 mem_rd  input  DATA_WIDTH  memory read data, 1-cycle synchronous latency.
REQ-012 mem_we  output  1  memory write strobe, one cycle per write.
REQ-013 mem_wd  output  DATA_WIDTH  full word written to memory.
REQ-014 misalign  output  1  sticky flag: an SW with A[1:0] != 0 was seen.

Function
REQ-015 FSM states: IDLE, READ, WRITE; reset state IDLE.
REQ-016 IDLE, WE=1, StSrc=0, A[1:0]=0: mem_we=1, mem_wd=WD, mem_addr from A, same cycle; stay IDLE; Stall=0; zero added latency.
REQ-017 IDLE, WE=1, StSrc=0, A[1:0]!=0: no write, misalign set next edge, stay IDLE, Stall=0.
REQ-018 IDLE, WE=1, StSrc=1: latch word address, lane A[1:0] and WD[7:0]; mem_re=1; Stall=1; next state READ.
REQ-019 READ: mem_re=0, mem_we=0, Stall=1; next state WRITE.
REQ-020 WRITE: mem_wd = mem_rd with lane byte replaced by latched byte (lane 0 = bits 7:0, lane 3 = bits 31:24, little-endian); mem_we=1; mem_addr = latched address; Stall=0; next state IDLE.
REQ-021 SB total occupancy: 3 cycles (IDLE accept, READ, WRITE); Stall high for exactly 2 cycles.
REQ-022 mem_addr in IDLE follows A combinationally; in READ/WRITE follows the latched address.
REQ-023 WE while in READ or WRITE shall not start a new request; a request held across WRITE is the same store and shall not be re-accepted: after WRITE the block ignores WE for one cycle in IDLE if A/StSrc are unchanged (done flag cleared on any IDLE cycle with WE=0 or differing request).
REQ-024 WE=0 in IDLE: mem_we=0, mem_re=0, Stall=0.
REQ-025 misalign clears only on rst.
REQ-026 mem_we and mem_re shall never be high in the same cycle.

Reset
REQ-027 rst high at an edge: state IDLE, misalign=0, latches and done flag cleared; outputs during/after reset cycle: Stall=0, mem_we=0, mem_re=0, mem_wd=0.
REQ-028 rst during READ or WRITE aborts the store; no memory write occurs in any cycle where rst is sampled high.

Structure
REQ-029 State enum (IDLE/READ/WRITE) and size encoding constants (SZ_WORD=0, SZ_BYTE=1) shall live in a shared package also used by the load-side formatter.
REQ-030 One sub-module, byte_merge: combinational insertion of a byte into a word by lane index; used in WRITE state.

Verification
REQ-031 SW A=0x100, WD=0xDEADBEEF -> same cycle mem_we=1, mem_addr=0x100, mem_wd=0xDEADBEEF, Stall=0.
REQ-032 SB A=0x102, WD=0x000000AB, memory word 0x11223344 -> Stall 1,1 then WRITE: mem_wd=0x11AB3344, mem_addr=0x100, exactly one mem_we pulse.
REQ-033 SB lanes 0 and 3 on word 0xFFFFFFFF with byte 0x00 -> 0xFFFFFF00 and 0x00FFFFFF.
REQ-034 SW A=0x101 -> no mem_we, misalign=1 next cycle, remains 1 after further aligned stores until rst.
REQ-035 rst asserted in READ state of an SB -> no mem_we ever issued, next cycle IDLE, Stall=0.
REQ-036 Back-to-back SB then SW (pipeline releases after Stall drops) -> SB write then SW write on following cycle, no duplicate SB write.
